// File: rtl/vec_pkg.sv
// Shared encodings and sizing for the vector lane ALU.
// Lane i of a packed vector occupies bits [lane_lo(i)+WIDTH-1 : lane_lo(i)].
package vec_pkg;
    localparam int DEF_LANES = 16;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_VEC_W = DEF_LANES * DEF_WIDTH;

    typedef enum logic [1:0] {
        OP_VADD  = 2'b00,
        OP_VSUB  = 2'b01,
        OP_VSMUL = 2'b10,
        OP_VDOT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int lane_lo(int lane, int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/vec_lane_alu_if.sv
// Control/operand/result bundle between the control unit, register file and lane ALU.
// master drives the request and operands; slave (the ALU) drives status and results.
interface vec_lane_alu_if #(
    parameter int LANES = vec_pkg::DEF_LANES,
    parameter int WIDTH = vec_pkg::DEF_WIDTH
);
    logic                   Start;
    vec_pkg::op_e           Op;
    logic [LANES*WIDTH-1:0] A_p;
    logic [LANES*WIDTH-1:0] B_p;
    logic [WIDTH-1:0]       Scalar;
    logic                   Busy;
    logic                   Done;
    logic [LANES*WIDTH-1:0] Result_p;
    logic [WIDTH-1:0]       Result_s;
    logic                   WR_p;
    logic                   WR_s;

    modport master (
        output Start, Op, A_p, B_p, Scalar,
        input  Busy, Done, Result_p, Result_s, WR_p, WR_s
    );

    modport slave (
        input  Start, Op, A_p, B_p, Scalar,
        output Busy, Done, Result_p, Result_s, WR_p, WR_s
    );
endinterface

// File: rtl/vec_lane_op.sv
// Single-lane combinational datapath, all arithmetic modulo 2^WIDTH, unsigned.
// Zero latency; the caller time-multiplexes it across lanes.
module vec_lane_op
    import vec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] scalar,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] acc_nxt
);
    logic [WIDTH-1:0] prod_ab;
    logic [WIDTH-1:0] prod_as;

    // Products are assigned into WIDTH-bit targets, keeping only the low half.
    always_comb begin
        prod_ab = a * b;
        prod_as = a * scalar;
        res     = '0;
        acc_nxt = acc;
        case (op)
            OP_VADD:  res     = a + b;
            OP_VSUB:  res     = a - b;
            OP_VSMUL: res     = prod_as;
            OP_VDOT:  acc_nxt = acc + prod_ab;
        endcase
    end
endmodule

// File: rtl/vec_lane_alu.sv
// Vector ALU stage: latches operands on Start, processes one lane per cycle, pulses Done.
// Done 16 edges after the Start edge; Start is ignored while Busy (no queueing).
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          Clk,
    input  logic          Rst_n,
    vec_lane_alu_if.slave bus
);
    localparam int               CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    op_e                    op_q;
    logic [LANES*WIDTH-1:0] a_q;
    logic [LANES*WIDTH-1:0] b_q;
    logic [WIDTH-1:0]       scalar_q;
    logic [WIDTH-1:0]       acc;

    logic                   busy;
    logic                   done;
    logic                   wr_p;
    logic                   wr_s;
    logic [LANES*WIDTH-1:0] result_p;
    logic [WIDTH-1:0]       result_s;

    logic [WIDTH-1:0]       lane_a;
    logic [WIDTH-1:0]       lane_b;
    logic [WIDTH-1:0]       lane_res;
    logic [WIDTH-1:0]       acc_nxt;

    assign lane_a = a_q[lane_lo(int'(cnt), WIDTH) +: WIDTH];
    assign lane_b = b_q[lane_lo(int'(cnt), WIDTH) +: WIDTH];

    vec_lane_op #(.WIDTH(WIDTH)) u_lane (
        .op      (op_q),
        .a       (lane_a),
        .b       (lane_b),
        .scalar  (scalar_q),
        .acc     (acc),
        .res     (lane_res),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_VADD;
            a_q      <= '0;
            b_q      <= '0;
            scalar_q <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_p     <= 1'b0;
            wr_s     <= 1'b0;
            result_p <= '0;
            result_s <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    wr_p <= 1'b0;
                    wr_s <= 1'b0;
                    if (bus.Start) begin
                        op_q     <= bus.Op;
                        a_q      <= bus.A_p;
                        b_q      <= bus.B_p;
                        scalar_q <= bus.Scalar;
                        cnt      <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (op_q == OP_VDOT) begin
                        acc <= acc_nxt;
                    end else begin
                        result_p[lane_lo(int'(cnt), WIDTH) +: WIDTH] <= lane_res;
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                        done  <= 1'b1;
                        wr_p  <= (op_q != OP_VDOT);
                        wr_s  <= (op_q == OP_VDOT);
                        if (op_q == OP_VDOT) begin
                            result_s <= acc_nxt;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    wr_p  <= 1'b0;
                    wr_s  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.WR_p     = wr_p;
    assign bus.WR_s     = wr_s;
    assign bus.Result_p = result_p;
    assign bus.Result_s = result_s;
endmodule
